// File: rtl/fu_pkg.sv
// Shared constants and state encoding for the functional-unit arbiter.
package fu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection. On a tie the requester that was not
// served last wins; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        grant       = 1'b0;
        grant_valid = |req;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/fu_arbiter.sv
// Shares one combinational functional unit between two requesters.
// A command is registered onto fu_a/fu_b/fu_op, the unit settles for one
// cycle, the result is captured and then returned on the owner's response
// handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a command; the granted requester sees ready
//   EXEC  | fu_* driven and stable; fu_f captured at the end of the cycle
//   RESP  | result offered to the owner until its resp_ready is seen
module fu_arbiter
    import fu_pkg::*;
#(
    parameter int DATA_W = fu_pkg::DATA_W,
    parameter int OP_W   = fu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_f,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_f,

    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    output logic [OP_W-1:0]   fu_op,
    input  logic [DATA_W-1:0] fu_f,

    output logic              busy
);

    state_t            state;
    state_t            state_nx;
    logic              owner;
    logic              last_grant;
    logic [DATA_W-1:0] result;
    logic              grant;
    logic              grant_valid;
    logic              accept;
    logic              resp_done;

    rr_arb2 u_rr_arb2 (
        .req         ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Ready only goes to a requester that is actually granted, so at most one
    // of the two is ever high, and never outside IDLE.
    assign req0_ready = (state == IDLE) && grant_valid && (grant == 1'b0);
    assign req1_ready = (state == IDLE) && grant_valid && (grant == 1'b1);

    // The granted requester's valid is high by construction of grant_valid.
    assign accept    = (state == IDLE) && grant_valid;
    assign resp_done = (state == RESP) && (owner ? resp1_ready : resp0_ready);

    assign resp0_valid = (state == RESP) && (owner == 1'b0);
    assign resp1_valid = (state == RESP) && (owner == 1'b1);
    assign resp0_f     = result;
    assign resp1_f     = result;
    assign busy        = (state != IDLE);

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (resp_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Command capture on accept and result capture at the end of EXEC.
    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fu_a       <= '0;
            fu_b       <= '0;
            fu_op      <= '0;
            result     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                fu_a       <= grant ? req1_a  : req0_a;
                fu_b       <= grant ? req1_b  : req0_b;
                fu_op      <= grant ? req1_op : req0_op;
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) result <= fu_f;
        end
    end

endmodule

// File: tb/tb_fu_arbiter.sv
// Directed bench for fu_arbiter with a stub unit f = a ^ b ^ op.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [7:0] resp0_f, resp1_f;
    logic [7:0] fu_a, fu_b, fu_f;
    logic [2:0] fu_op;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fu_f = fu_a ^ fu_b ^ {5'b0, fu_op};

    fu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_f     (resp0_f),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_f     (resp1_f),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_op       (fu_op),
        .fu_f        (fu_f),
        .busy        (busy)
    );

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/r0v/r1v=%b expected 000", {busy, resp0_valid, resp1_valid});
        end
        checks++;
        if ({fu_a, fu_b, fu_op} !== 19'h0) begin
            errors++;
            $display("FAIL reset_fu: got a=%h b=%h op=%h expected 0", fu_a, fu_b, fu_op);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        req0_a = 8'h3C; req0_b = 8'h0F; req0_op = 3'b001; req0_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got r0/r1=%b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if ({busy, resp0_valid} !== 2'b10) begin
            errors++;
            $display("FAIL single_exec: got busy/r0v=%b expected 10", {busy, resp0_valid});
        end
        @(negedge clk);
        checks++;
        if ({resp0_valid, resp1_valid, resp0_f} !== {2'b10, 8'h32}) begin
            errors++;
            $display("FAIL single_resp: got v=%b f=%h expected v=10 f=32", {resp0_valid, resp1_valid}, resp0_f);
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        checks++;
        if ({busy, resp0_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_done: got busy/r0v=%b expected 00", {busy, resp0_valid});
        end
        checks++;
        if (fu_a !== 8'h3C) begin
            errors++;
            $display("FAIL single_fu_hold: got fu_a=%h expected 3c", fu_a);
        end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({fu_a, fu_b, fu_op, busy} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset: got a=%h b=%h op=%h busy=%b expected all 0", fu_a, fu_b, fu_op, busy);
        end
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie_alternate();
        int          n;
        logic [3:0]  who;
        logic [31:0] fs;
        n = 0; who = '0; fs = '0;
        req0_a = 8'hA5; req0_b = 8'h5A; req0_op = 3'b000; req0_valid = 1'b1;
        req1_a = 8'h01; req1_b = 8'h02; req1_op = 3'b111; req1_valid = 1'b1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first_grant: got r0/r1=%b expected 10", {req0_ready, req1_ready});
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (n < 4 && resp0_valid) begin who[n] = 1'b0; fs[n*8 +: 8] = resp0_f; n++; end
            else if (n < 4 && resp1_valid) begin who[n] = 1'b1; fs[n*8 +: 8] = resp1_f; n++; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL tie_count: got %0d responses expected 4", n);
        end
        checks++;
        if (who !== 4'b1010) begin
            errors++;
            $display("FAIL tie_order: got owners(n3..n0)=%b expected 1010", who);
        end
        checks++;
        if (fs !== 32'h04FF04FF) begin
            errors++;
            $display("FAIL tie_results: got %h expected 04ff04ff", fs);
        end
    endtask

    task automatic test_backpressure();
        req1_a = 8'h55; req1_b = 8'h0F; req1_op = 3'b010; req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: got req1_ready=%b expected 1", req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        req0_a = 8'h99; req0_b = 8'h99; req0_op = 3'b000; req0_valid = 1'b1;
        resp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({resp1_valid, resp0_valid, resp1_f, req0_ready, req1_ready} !== {2'b10, 8'h58, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got r1v=%b r0v=%b f=%h rdy=%b expected 1 0 58 00",
                         i, resp1_valid, resp0_valid, resp1_f, {req0_ready, req1_ready});
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; resp0_ready = 1'b0;
        resp1_ready = 1'b1;
        @(negedge clk);
        resp1_ready = 1'b0;
        checks++;
        if ({busy, resp1_valid} !== 2'b00) begin
            errors++;
            $display("FAIL bp_release: got busy/r1v=%b expected 00", {busy, resp1_valid});
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        int lat;
        seen = 0;
        req0_a = 8'h77; req0_b = 8'h11; req0_op = 3'b011; req0_valid = 1'b1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_exec: got busy=%b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, fu_a} !== 9'h0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b fu_a=%h expected 0 00", busy, fu_a);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_no_resp: got %0d response cycles expected 0", seen);
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        req1_a = 8'h20; req1_b = 8'h03; req1_op = 3'b100; req1_valid = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            req1_valid = 1'b0;
            if (resp1_valid) break;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL mid_latency: got %0d cycles expected 2", lat);
        end
        checks++;
        if (resp1_f !== 8'h27) begin
            errors++;
            $display("FAIL mid_result: got %h expected 27", resp1_f);
        end
        resp1_ready = 1'b1;
        @(negedge clk);
        resp1_ready = 1'b0;
    endtask

    task automatic test_operand_change();
        req0_a = 8'h10; req0_b = 8'h01; req0_op = 3'b000; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        req0_a = 8'hFF;
        #1;
        checks++;
        if (fu_a !== 8'h10) begin
            errors++;
            $display("FAIL opchg_fu_a: got %h expected 10", fu_a);
        end
        @(negedge clk);
        checks++;
        if ({resp0_valid, resp0_f} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL opchg_result: got v=%b f=%h expected 1 11", resp0_valid, resp0_f);
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL opchg_done: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        test_reset();
        test_single();
        test_async_reset();
        test_tie_alternate();
        test_backpressure();
        test_reset_mid_op();
        test_operand_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_arbiter.md
Name: fu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational Functional_Unit (8-bit A/B, 3-bit instruction, 8-bit F) between two requesters.
- Each requester presents operands and an instruction over a valid/ready handshake. The block registers them, drives the shared unit, captures F, and returns it on a per-requester response handshake.
- Sits between client blocks (for example a sequencer or a host port) and the single Functional_Unit instance.

Parameters:
- DATA_W, 8, operand/result width; must match Functional_Unit A/B/F.
- OP_W, 3, instruction width; must match Functional_Unit instruction.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  arbiter accepts requester 0 command this cycle.
- req0_a, req0_b  in  DATA_W each  requester 0 operands.
- req0_op  in  OP_W  requester 0 instruction.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- resp0_valid  out  1  result for requester 0 is available.
- resp0_ready  in  1  requester 0 takes the result.
- resp0_f  out  DATA_W  result for requester 0.
- resp1_valid, resp1_ready, resp1_f: same as requester 0, for requester 1.
- fu_a, fu_b  out  DATA_W  to Functional_Unit A, B (registered).
- fu_op  out  OP_W  to Functional_Unit instruction (registered).
- fu_f  in  DATA_W  from Functional_Unit F.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: already decided — one clock; reset is asynchronous and active-high (rst).
  - On rst: state=IDLE; fu_a=fu_b=0; fu_op=0; result register=0; owner=0; last_grant=1, so requester 0 wins the first tie.
  - All resp*_valid=0 and busy=0 while rst is high and immediately after.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection:
    - only req0_valid → grant 0;
    - only req1_valid → grant 1;
    - both valid → grant the requester that is not last_grant.
  - req_ready is combinational: reqN_ready = (state==IDLE) && (grant==N). It is never high for both requesters and never high outside IDLE.
  - On reqN_valid && reqN_ready:
    - load fu_a/fu_b/fu_op from requester N;
    - owner=N; last_grant=N;
    - go to EXEC.
  - No valid: stay in IDLE; all registers hold.
- EXEC (one cycle):
  - fu_* are stable, so Functional_Unit settles combinationally.
  - At cycle end, capture fu_f into the result register; go to RESP.
- RESP:
  - resp[owner]_valid=1 and resp[owner]_f=result register; the other resp_valid=0.
  - Data stays stable while valid is high and ready is low.
  - On resp[owner]_ready: go to IDLE next cycle. The ready of the non-owner is ignored.
- Latency and throughput:
  - Accept edge t → resp_valid high from t+2.
  - Minimum 3 cycles per transaction, with no accept in the same cycle as a response handshake.
- fu_* hold their last command after completion. They change only on an accept.
- Requester protocol:
  - A requester that drops valid before acceptance is not serviced and causes no state change.
  - Operands are sampled only on the accept edge; later changes have no effect.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1…
- Reset in any state (mid EXEC or RESP): the transaction is discarded with no response issued; outputs return to reset values asynchronously.

Decomposition:
- Shared package fu_pkg:
  - DATA_W and OP_W constants;
  - state encoding typedef (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- The round-robin grant logic is a natural sub-module rr_arb2: inputs req[1:0] and last_grant; output grant index and grant_valid.
- Functional_Unit is instantiated beside fu_arbiter at top level, not inside it.

Test Plan:
- The bench uses a stub FU with fu_f = fu_a ^ fu_b ^ {5'b0, fu_op}. A second run uses the real Functional_Unit against its golden model.
- Reset: assert rst mid-cycle with no clock edge → busy=0, resp0_valid=resp1_valid=0, fu_a=fu_b=8'h00, fu_op=3'b000 immediately.
- Single request: req0 a=8'h3C, b=8'h0F, op=3'b001, valid at edge t → req0_ready=1 at t; resp0_valid=1 and resp0_f=8'h32 from t+2; resp1_valid stays 0.
- Tie after reset: req0 (8'hA5, 8'h5A, 3'b000) and req1 (8'h01, 8'h02, 3'b111) both valid → requester 0 served first (resp0_f=8'hFF), then requester 1 (resp1_f=8'h04). Continuous requests alternate 0,1,0,1.
- Response backpressure: hold resp1_ready=0 for 5 cycles → resp1_valid and resp1_f stay stable, req*_ready=0 throughout; ready high → IDLE on the next cycle.
- Reset mid-operation: pulse rst while in EXEC → no response is ever issued for that command; the next req1 command completes normally with latency 2.
- Operand change after accept: change req0_a from 8'h10 to 8'hFF one cycle after accept → result still reflects 8'h10.
